// File: rtl/sn74ls_serial_rx.sv
// Serial frame receiver: start bit, WIDTH data bits MSB first, optional parity, stop bit.
// Optional parity slot enabled by defining SN74LS_SERIAL_RX_PARITY_EN.
module sn74ls_serial_rx #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             en,
  input  logic             ser,
  output logic [WIDTH-1:0] q,
  output logic             rdy,
  output logic             ferr,
  output logic             busy,
  output logic             perr
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    STOP = 2'd2
`ifdef SN74LS_SERIAL_RX_PARITY_EN
    ,
    PAR  = 2'd3
`endif
  } state_t;

  state_t           state;
  state_t           state_n;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] sr;
  logic             load;
  logic             frame_err;
  logic             start;
  logic             shift;
  logic             par_calc;

  function automatic logic odd_parity(input logic [WIDTH-1:0] d, input logic p);
    return (^d) ^ p;
  endfunction

`ifdef SN74LS_SERIAL_RX_PARITY_EN
  logic par_bit;
  logic perr_r;

  always_ff @(posedge clk) begin
    if (!clr) begin
      par_bit <= 1'b0;
      perr_r  <= 1'b0;
    end else begin
      if (en && state == PAR) par_bit <= ser;
      perr_r <= load & par_calc;
    end
  end

  assign par_calc = odd_parity(sr, par_bit);
  assign perr     = perr_r;
`else
  assign par_calc = 1'b0;
  assign perr     = 1'b0;
`endif

  // Next-state logic; nothing advances on edges without the bit strobe.
  always_comb begin
    state_n   = state;
    load      = 1'b0;
    frame_err = 1'b0;
    start     = 1'b0;
    shift     = 1'b0;
    if (en) begin
      case (state)
        IDLE: begin
          if (ser == 1'b0) begin
            state_n = DATA;
            start   = 1'b1;
          end
        end
        DATA: begin
          shift = 1'b1;
          if (cnt == CW'(WIDTH - 1)) begin
`ifdef SN74LS_SERIAL_RX_PARITY_EN
            state_n = PAR;
`else
            state_n = STOP;
`endif
          end
        end
`ifdef SN74LS_SERIAL_RX_PARITY_EN
        PAR: state_n = STOP;
`endif
        STOP: begin
          state_n = IDLE;
          if (ser) load = 1'b1;
          else     frame_err = 1'b1;
        end
        default: state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!clr) begin
      state <= IDLE;
      cnt   <= '0;
      sr    <= '0;
      q     <= '0;
      rdy   <= 1'b0;
      ferr  <= 1'b0;
    end else begin
      state <= state_n;
      rdy   <= load;
      ferr  <= frame_err;
      if (start) cnt <= '0;
      if (shift) begin
        sr  <= {sr[WIDTH-2:0], ser};
        cnt <= cnt + 1'b1;
      end
      if (load) q <= sr;
    end
  end

  assign busy = (state != IDLE);

endmodule
